mul_arbiter_fp32: RTL and testbench

MUL_ARBITER_FP32 -- requirements
Module: mul_arbiter_fp32

---
 rtl/mul_arbiter_fp32.sv | 199 +++++++++++++++++++
 tb/tb_mul_arbiter_fp32.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_arbiter_fp32.sv
// Two-requester round-robin front end for one shared multiplier_fp32.
// Grants one request at a time, supervises the multiply with a timeout, and returns the result to the granted port.
module mul_arbiter_fp32 #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] x0,
  input  logic [31:0] y0,
  input  logic [31:0] x1,
  input  logic [31:0] y1,
  output logic        ack0,
  output logic        ack1,
  output logic        done0,
  output logic        done1,
  output logic [31:0] z0,
  output logic [31:0] z1,
  output logic        err0,
  output logic        err1,
  output logic        mul_rd,
  output logic [31:0] mul_x,
  output logic [31:0] mul_y,
  input  logic        mul_wr,
  input  logic [31:0] mul_z,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [31:0]   QNAN     = 32'h7FC0_0000;

  state_t        state_q, state_d;
  logic          ptr_q, ptr_d;
  logic          gnt_q, gnt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          ack0_q, ack0_d, ack1_q, ack1_d;
  logic          done0_q, done0_d, done1_q, done1_d;
  logic          err0_q, err0_d, err1_q, err1_d;
  logic [31:0]   z0_q, z0_d, z1_q, z1_d;
  logic          mul_rd_q, mul_rd_d;
  logic [31:0]   mul_x_q, mul_x_d, mul_y_q, mul_y_d;
  logic          busy_q, busy_d;

  logic          win_s;
  logic          grant_s;
  logic          take_s;
  logic          tmo_s;

  // Round-robin winner and the events that drive the FSM.
  always_comb begin
    win_s = 1'b0;
    if (req0 && req1) begin
      win_s = ptr_q;
    end else if (req1) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
    grant_s = (state_q == IDLE) && (req0 || req1);
    take_s  = (state_q == WAIT) && mul_wr;
    // A result arriving in the last WAIT cycle beats the timeout.
    tmo_s   = (state_q == WAIT) && !mul_wr && (cnt_q == CNT_LAST);
  end

  // Next state, arbitration pointer, granted port and WAIT counter.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (grant_s) begin
          state_d = ISSUE;
          gnt_d   = win_s;
          ptr_d   = ~win_s;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = {CW{1'b0}};
      end
      WAIT: begin
        if (take_s || tmo_s) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered output values for the next cycle.
  always_comb begin
    ack0_d   = grant_s && !win_s;
    ack1_d   = grant_s && win_s;
    mul_rd_d = grant_s;
    if (grant_s) begin
      mul_x_d = win_s ? x1 : x0;
      mul_y_d = win_s ? y1 : y0;
    end else begin
      mul_x_d = mul_x_q;
      mul_y_d = mul_y_q;
    end
    done0_d = (take_s || tmo_s) && !gnt_q;
    done1_d = (take_s || tmo_s) && gnt_q;
    err0_d  = tmo_s && !gnt_q;
    err1_d  = tmo_s && gnt_q;
    z0_d    = z0_q;
    z1_d    = z1_q;
    if (take_s) begin
      if (gnt_q) begin
        z1_d = mul_z;
      end else begin
        z0_d = mul_z;
      end
    end else if (tmo_s) begin
      if (gnt_q) begin
        z1_d = QNAN;
      end else begin
        z0_d = QNAN;
      end
    end else begin
      z0_d = z0_q;
    end
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b0;
      gnt_q    <= 1'b0;
      cnt_q    <= {CW{1'b0}};
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      z0_q     <= 32'h0000_0000;
      z1_q     <= 32'h0000_0000;
      mul_rd_q <= 1'b0;
      mul_x_q  <= 32'h0000_0000;
      mul_y_q  <= 32'h0000_0000;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      cnt_q    <= cnt_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
      z0_q     <= z0_d;
      z1_q     <= z1_d;
      mul_rd_q <= mul_rd_d;
      mul_x_q  <= mul_x_d;
      mul_y_q  <= mul_y_d;
      busy_q   <= busy_d;
    end
  end

  assign ack0   = ack0_q;
  assign ack1   = ack1_q;
  assign done0  = done0_q;
  assign done1  = done1_q;
  assign err0   = err0_q;
  assign err1   = err1_q;
  assign z0     = z0_q;
  assign z1     = z1_q;
  assign mul_rd = mul_rd_q;
  assign mul_x  = mul_x_q;
  assign mul_y  = mul_y_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_mul_arbiter_fp32.sv
// Directed bench for mul_arbiter_fp32 with a behavioural multiplier stub of programmable latency.
module tb_mul_arbiter_fp32;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [31:0] x0, y0, x1, y1;
  logic        ack0, ack1, done0, done1, err0, err1;
  logic [31:0] z0, z1;
  logic        mul_rd, mul_wr;
  logic [31:0] mul_x, mul_y, mul_z;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_arbiter_fp32 #(.TIMEOUT(64)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
    .z0(z0), .z1(z1), .err0(err0), .err1(err1),
    .mul_rd(mul_rd), .mul_x(mul_x), .mul_y(mul_y),
    .mul_wr(mul_wr), .mul_z(mul_z), .busy(busy)
  );

  // Multiplier stub: mul_wr comes stub_lat cycles after mul_rd is seen (0 = never).
  int          stub_lat = 0;
  int          stub_cnt = 0;
  logic        force_wr = 1'b0;
  logic [31:0] stub_z   = 32'h0000_0000;

  always @(posedge clk) begin
    if (mul_rd) stub_cnt <= stub_lat;
    else if (stub_cnt > 0) stub_cnt <= stub_cnt - 1;
  end

  always_comb begin
    mul_wr = force_wr | (stub_cnt == 1);
    if (mul_x == 32'h42F6_0000 && mul_y == 32'h42F6_0000) mul_z = 32'h466C_6400;
    else if (mul_x == 32'hC22C_0000 && mul_y == 32'h422C_0000) mul_z = 32'hC4E7_2000;
    else mul_z = stub_z;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // port: 0/1 = that port acked, 2 = both at once, -1 = none within bound.
  task automatic wait_ack(output int port, output int n);
    bit found = 1'b0;
    port = -1;
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        port  = (ack0 && ack1) ? 2 : (ack1 ? 1 : 0);
        n     = i;
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: got no ack, expected ack within 200 cycles");
    end
  endtask

  task automatic wait_done(output int port, output int n, output int rd_cnt);
    bit found = 1'b0;
    port = -1;
    n = 0;
    rd_cnt = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (mul_rd) rd_cnt++;
      if (done0 || done1) begin
        port  = (done0 && done1) ? 2 : (done1 ? 1 : 0);
        n     = i;
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done, expected done within 200 cycles");
    end
  endtask

  typedef struct {
    int          port;   // requesting port
    logic [31:0] xa, ya;
    int          lat;    // stub latency, 0 = never answers
    logic [31:0] sz;     // stub result when not a known operand pair
    logic [31:0] ez;
    logic        eerr;
    int          elat;   // cycles from ack to done
  } vec_t;

  vec_t vecs[5];

  initial begin
    int p, n, rd;
    logic [31:0] zs;

    vecs[0] = '{0, 32'h42F6_0000, 32'h42F6_0000, 5,  32'h0000_0000, 32'h466C_6400, 1'b0, 6};
    vecs[1] = '{1, 32'hC22C_0000, 32'h422C_0000, 3,  32'h0000_0000, 32'hC4E7_2000, 1'b0, 4};
    vecs[2] = '{0, 32'h3F80_0000, 32'h4000_0000, 0,  32'h4000_0000, 32'h7FC0_0000, 1'b1, 65};
    vecs[3] = '{0, 32'h3F80_0000, 32'h3F80_0000, 64, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 65};
    vecs[4] = '{1, 32'h4000_0000, 32'h4040_0000, 1,  32'h40C0_0000, 32'h40C0_0000, 1'b0, 2};

    reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
    x0 = 32'h0; y0 = 32'h0; x1 = 32'h0; y1 = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_busy",   {31'd0, busy}, 32'd0);
    check("rst_ack",    {30'd0, ack1, ack0}, 32'd0);
    check("rst_done",   {30'd0, done1, done0}, 32'd0);
    check("rst_err",    {30'd0, err1, err0}, 32'd0);
    check("rst_mul_rd", {31'd0, mul_rd}, 32'd0);
    check("rst_z0",     z0, 32'h0);
    check("rst_z1",     z1, 32'h0);
    check("rst_mul_x",  mul_x, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Single-requester vectors.
    for (int v = 0; v < 5; v++) begin
      req0 = (vecs[v].port == 0);
      req1 = (vecs[v].port == 1);
      x0 = (vecs[v].port == 0) ? vecs[v].xa : 32'hDEAD_BEEF;
      y0 = (vecs[v].port == 0) ? vecs[v].ya : 32'hDEAD_BEEF;
      x1 = (vecs[v].port == 1) ? vecs[v].xa : 32'hDEAD_BEEF;
      y1 = (vecs[v].port == 1) ? vecs[v].ya : 32'hDEAD_BEEF;
      stub_lat = vecs[v].lat;
      stub_z   = vecs[v].sz;
      wait_ack(p, n);
      check("vec_ack_port", p, vecs[v].port);
      check("vec_ack_lat",  n, 1);
      check("vec_mul_rd",   {31'd0, mul_rd}, 32'd1);
      check("vec_busy",     {31'd0, busy}, 32'd1);
      check("vec_mul_x",    mul_x, vecs[v].xa);
      check("vec_mul_y",    mul_y, vecs[v].ya);
      req0 = 1'b0;
      req1 = 1'b0;
      wait_done(p, n, rd);
      zs = (vecs[v].port == 1) ? z1 : z0;
      check("vec_done_port", p, vecs[v].port);
      check("vec_done_lat",  n, vecs[v].elat);
      check("vec_z",         zs, vecs[v].ez);
      check("vec_err",       {31'd0, (vecs[v].port == 1) ? err1 : err0}, {31'd0, vecs[v].eerr});
      check("vec_err_other", {31'd0, (vecs[v].port == 1) ? err0 : err1}, 32'd0);
      check("vec_extra_rd",  rd, 0);
      @(negedge clk);
      check("vec_done_drop", {30'd0, done1, done0}, 32'd0);
      check("vec_err_drop",  {30'd0, err1, err0}, 32'd0);
      check("vec_busy_idle", {31'd0, busy}, 32'd0);
      check("vec_z_hold",    (vecs[v].port == 1) ? z1 : z0, vecs[v].ez);
      repeat (2) @(negedge clk);
    end

    // Both requesters held from reset release: strict alternation, reqs ignored during reset.
    reset = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    x0 = 32'h42F6_0000; y0 = 32'h42F6_0000;
    x1 = 32'hC22C_0000; y1 = 32'h422C_0000;
    stub_lat = 4;
    repeat (2) @(negedge clk);
    check("rr_reset_ack", {30'd0, ack1, ack0}, 32'd0);
    check("rr_reset_busy", {31'd0, busy}, 32'd0);
    check("rr_reset_z0", z0, 32'h0);
    reset = 1'b0;
    for (int r = 0; r < 4; r++) begin
      wait_ack(p, n);
      check("rr_ack_port", p, r % 2);
      check("rr_ack_gap", n, (r == 0) ? 1 : 2);
      check("rr_mul_x", mul_x, (r % 2 == 1) ? 32'hC22C_0000 : 32'h42F6_0000);
      wait_done(p, n, rd);
      check("rr_done_port", p, r % 2);
      check("rr_z", (r % 2 == 1) ? z1 : z0, (r % 2 == 1) ? 32'hC4E7_2000 : 32'h466C_6400);
      check("rr_err", {30'd0, err1, err0}, 32'd0);
      if (r == 3) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
    end
    repeat (3) @(negedge clk);

    // Reset during WAIT; the stub answers 3 cycles later into an idle block.
    req0 = 1'b1; x0 = 32'h3F80_0000; y0 = 32'h4000_0000;
    stub_lat = 5; stub_z = 32'h4000_0000;
    wait_ack(p, n);
    check("rst_wait_ack", p, 0);
    req0 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done0 || done1 || busy || ack0 || ack1) n++;
    end
    check("rst_wait_no_done", n, 0);
    check("rst_wait_z0", z0, 32'h0);
    check("rst_wait_mul_x", mul_x, 32'h0);
    check("rst_wait_err", {30'd0, err1, err0}, 32'd0);

    // Spurious mul_wr in IDLE, then req1 held through its done is served again.
    force_wr = 1'b1;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done0 || done1 || busy) n++;
    end
    force_wr = 1'b0;
    check("spur_no_done", n, 0);
    req1 = 1'b1; x1 = 32'h4000_0000; y1 = 32'h4040_0000;
    stub_lat = 2; stub_z = 32'h40C0_0000;
    for (int r = 0; r < 2; r++) begin
      wait_ack(p, n);
      check("held_ack_port", p, 1);
      check("held_ack_gap", n, (r == 0) ? 1 : 2);
      if (r == 1) req1 = 1'b0;
      wait_done(p, n, rd);
      check("held_done_port", p, 1);
      check("held_z1", z1, 32'h40C0_0000);
    end
    n = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ack0 || ack1 || done0 || done1) n++;
    end
    check("held_no_dup", n, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
